display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one BCD-to-seven-segment decoder across `NUM_DIGITS` common-anode digits. It holds a display value and drives the decoder's 4-bit digit input and the active-low anode enables, one digit per slot. Each slot starts with an anti-ghosting blank interval. Leading-zero suppression is optional. New values are accepted through a load strobe and committed only at a frame boundary, so the display never shows a torn value. It sits between the number-conversion datapath (binary/Gray/decimal result) and the segment decoder that drives `catodo`.

---
 rtl/display_scan_ctrl.sv | 63 ++++++
 tb/tb_display_scan_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed BCD digit scanner with anti-ghost blanking,
// optional leading-zero suppression and frame-aligned commit of loaded values.
module display_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_bcd,
   input  logic                    blank_lz,
   output logic [3:0]              digit,
   output logic [NUM_DIGITS-1:0]   anodo,
   output logic                    pending,
   output logic                    frame_tick
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
   logic [CW-1:0]           r_cnt;
   logic [IW-1:0]           r_idx;
   logic [4*NUM_DIGITS-1:0] r_disp;
   logic [4*NUM_DIGITS-1:0] r_pend_val;
   logic                    r_pending;
   logic                    w_slot_end;
   logic [NUM_DIGITS-1:0]   w_nz;
   assign w_slot_end = r_cnt == CNT_LAST;
   assign frame_tick = w_slot_end && r_idx == IDX_LAST;
   assign pending    = r_pending;
   assign digit      = r_disp[4*r_idx +: 4];
   // w_nz[i] is set when nibble i or any more-significant nibble is non-zero
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nz
      assign w_nz[i] = |r_disp[4*NUM_DIGITS-1:4*i];
   end
   always_comb begin
      anodo = '1;
      anodo[r_idx] = !(r_cnt >= CNT_BLANK && (w_nz[r_idx] || r_idx == '0 || !blank_lz));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_disp     <= '0;
         r_pend_val <= '0;
         r_pending  <= 1'b0;
      end else begin
         r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
         if (w_slot_end)
            r_idx <= r_idx == IDX_LAST ? '0 : r_idx + 1'b1;
         // a load on the commit edge bypasses the pending register entirely
         if (frame_tick) begin
            r_disp    <= load ? value_bcd : (r_pending ? r_pend_val : r_disp);
            r_pending <= 1'b0;
         end else if (load) begin
            r_pend_val <= value_bcd;
            r_pending  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed stimulus with cycle-stamped expectations queued
// for a negedge monitor that compares anodo/digit/pending/frame_tick.
module tb_display_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value_bcd = '0;
   logic        blank_lz = 1'b0;
   logic [3:0]  digit;
   logic [3:0]  anodo;
   logic        pending;
   logic        frame_tick;

   display_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .load(load), .value_bcd(value_bcd), .blank_lz(blank_lz),
      .digit(digit), .anodo(anodo), .pending(pending), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int          tcyc = 0;
   int          base = 0;
   int          checks = 0;
   int          errors = 0;
   int          qc[$];
   logic [9:0]  qv[$];
   string       qn[$];

   always @(posedge clk) tcyc <= tcyc + 1;

   always @(negedge clk) begin
      while (qc.size() != 0 && qc[0] <= tcyc) begin
         int         c;
         logic [9:0] v;
         logic [9:0] got;
         string      n;
         c = qc.pop_front();
         v = qv.pop_front();
         n = qn.pop_front();
         got = {anodo, digit, pending, frame_tick};
         checks++;
         if (c != tcyc || got !== v) begin
            errors++;
            $display("FAIL %s @k=%0d (at %0d): got anodo=%b digit=%h pending=%b tick=%b, want anodo=%b digit=%h pending=%b tick=%b",
                     n, c - base, tcyc - base, got[9:6], got[5:2], got[1], got[0], v[9:6], v[5:2], v[1], v[0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int k);
      while (tcyc < base + k) step();
   endtask

   task automatic ex(input int k, input string n, input logic [3:0] an, input logic [3:0] dg,
                     input logic pd, input logic ft);
      qc.push_back(base + k);
      qv.push_back({an, dg, pd, ft});
      qn.push_back(n);
   endtask

   task automatic pulse(input logic [15:0] v);
      load = 1'b1;
      value_bcd = v;
      step();
      load = 1'b0;
   endtask

   initial begin
      step();
      step();
      base = tcyc;
      ex(0, "reset_state", 4'b1111, 4'h0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      base = tcyc;
      ex(0,  "run_k0",    4'b1111, 4'h0, 1'b0, 1'b0);
      ex(1,  "run_blank", 4'b1111, 4'h0, 1'b0, 1'b0);
      ex(2,  "run_an0",   4'b1110, 4'h0, 1'b0, 1'b0);
      ex(7,  "run_an0_end", 4'b1110, 4'h0, 1'b0, 1'b0);
      ex(8,  "run_slot1_blank", 4'b1111, 4'h0, 1'b0, 1'b0);
      ex(10, "run_an1",   4'b1101, 4'h0, 1'b0, 1'b0);
      ex(18, "run_an2",   4'b1011, 4'h0, 1'b0, 1'b0);
      ex(26, "run_an3",   4'b0111, 4'h0, 1'b0, 1'b0);
      ex(31, "tick31",    4'b0111, 4'h0, 1'b0, 1'b1);
      ex(32, "after_tick", 4'b1111, 4'h0, 1'b0, 1'b0);
      ex(34, "frame2_an0", 4'b1110, 4'h0, 1'b0, 1'b0);
      ex(63, "tick63",    4'b0111, 4'h0, 1'b0, 1'b1);
      goto(64);
      ex(74,  "pre_load",     4'b1101, 4'h0, 1'b0, 1'b0);
      ex(75,  "pending_rise", 4'b1101, 4'h0, 1'b1, 1'b0);
      ex(95,  "pending_tick", 4'b0111, 4'h0, 1'b1, 1'b1);
      ex(96,  "commit_1234",  4'b1111, 4'h4, 1'b0, 1'b0);
      ex(98,  "d0_is_4",      4'b1110, 4'h4, 1'b0, 1'b0);
      ex(106, "d1_is_3",      4'b1101, 4'h3, 1'b0, 1'b0);
      ex(114, "d2_is_2",      4'b1011, 4'h2, 1'b0, 1'b0);
      ex(122, "d3_is_1",      4'b0111, 4'h1, 1'b0, 1'b0);
      goto(74);
      pulse(16'h1234);
      goto(124);
      ex(128, "lz47_commit",  4'b1111, 4'h7, 1'b0, 1'b0);
      ex(130, "lz47_d0",      4'b1110, 4'h7, 1'b0, 1'b0);
      ex(138, "lz47_d1",      4'b1101, 4'h4, 1'b0, 1'b0);
      ex(146, "lz47_d2_supp", 4'b1111, 4'h0, 1'b0, 1'b0);
      ex(151, "lz47_d2_late", 4'b1111, 4'h0, 1'b1, 1'b0);
      ex(154, "lz47_d3_supp", 4'b1111, 4'h0, 1'b1, 1'b0);
      ex(159, "lz47_tick",    4'b1111, 4'h0, 1'b1, 1'b1);
      ex(162, "lz0_d0_on",    4'b1110, 4'h0, 1'b0, 1'b0);
      ex(170, "lz0_d1_supp",  4'b1111, 4'h0, 1'b0, 1'b0);
      ex(178, "lz0_d2_supp",  4'b1111, 4'h0, 1'b0, 1'b0);
      ex(186, "lz0_d3_supp",  4'b1111, 4'h0, 1'b0, 1'b0);
      blank_lz = 1'b1;
      pulse(16'h0047);
      goto(150);
      pulse(16'h0000);
      goto(196);
      blank_lz = 1'b0;
      ex(201, "lww_pend1",    4'b1111, 4'h0, 1'b1, 1'b0);
      ex(203, "lww_pend2",    4'b1101, 4'h0, 1'b1, 1'b0);
      ex(223, "lww_tick",     4'b0111, 4'h0, 1'b1, 1'b1);
      ex(224, "lww_commit",   4'b1111, 4'h2, 1'b0, 1'b0);
      ex(250, "lww_d3_2222",  4'b0111, 4'h2, 1'b0, 1'b0);
      goto(200);
      pulse(16'h1111);
      goto(202);
      pulse(16'h2222);
      goto(252);
      ex(255, "tickload_pre", 4'b0111, 4'h2, 1'b0, 1'b1);
      ex(256, "tickload_d6",  4'b1111, 4'h6, 1'b0, 1'b0);
      ex(257, "tickload_blank", 4'b1111, 4'h6, 1'b0, 1'b0);
      ex(258, "tickload_an0", 4'b1110, 4'h6, 1'b0, 1'b0);
      ex(266, "tickload_d1",  4'b1101, 4'h7, 1'b1, 1'b0);
      goto(255);
      pulse(16'h9876);
      goto(260);
      ex(268, "pre_rst",      4'b1101, 4'h7, 1'b1, 1'b0);
      ex(269, "rst_mid",      4'b1111, 4'h0, 1'b0, 1'b0);
      ex(270, "rst_hold",     4'b1111, 4'h0, 1'b0, 1'b0);
      ex(273, "post_rst_an0", 4'b1110, 4'h0, 1'b0, 1'b0);
      ex(281, "post_rst_an1", 4'b1101, 4'h0, 1'b0, 1'b0);
      ex(302, "post_rst_tick", 4'b0111, 4'h0, 1'b0, 1'b1);
      ex(303, "post_rst_disp0", 4'b1111, 4'h0, 1'b0, 1'b0);
      goto(262);
      pulse(16'h5555);
      goto(269);
      rst = 1'b1;
      goto(271);
      rst = 1'b0;
      goto(305);
      for (int i = 0; i < 50 && qc.size() != 0; i++) step();
      if (qc.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", qc.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
